pito_irq_ctrl: RTL
==================

// Module: pito_irq_ctrl
// PURPOSE
//  Per-hart machine interrupt controller and trap scheduler for the NUM_HARTS-way barrel core.
//  - Holds each hart's MIP state (MSIP, MTIP, MEIP, MVIP), masks it with the hart's MIE and mstatus.MIE.
//  - Round-robin picks one hart at a time and offers its interrupt (hart id + mcause) to the core on a valid/ack handshake.
//  - Sits between the MVU/timer/external interrupt sources and the core's CSR/trap logic.
// PARAMETERS
//  NUM_HARTS       8                   number of hardware threads
//  HART_CNT_WIDTH  $clog2(NUM_HARTS)   hart index width
//  XPR_LEN         32                  CSR width
// PORTS
//  clk             in   1                   core clock
//  rst             in   1                   synchronous reset, active high
//  ext_irq_i       in   NUM_HARTS           level: external interrupt per hart, drives MEIP
//  timer_irq_i     in   NUM_HARTS           level: timer compare per hart, drives MTIP
//  sw_irq_set_i    in   NUM_HARTS           pulse: set MSIP
//  sw_irq_clr_i    in   NUM_HARTS           pulse: clear MSIP
//  mvu_irq_i       in   NUM_HARTS           pulse: MVU job done, sets MVIP
//  mvu_irq_clr_i   in   NUM_HARTS           pulse: clear MVIP
//  mie_i           in   NUM_HARTS*XPR_LEN   per-hart MIE CSR; hart h at [h*XPR_LEN +: XPR_LEN]
//  mstatus_mie_i   in   NUM_HARTS           per-hart mstatus.MIE
//  mret_i          in   NUM_HARTS           pulse: hart executed MRET
//  irq_ack_i       in   1                   core takes the offered trap
//  mip_o           out  NUM_HARTS*XPR_LEN   per-hart MIP for CSR reads; only bits 3, 7, 11, 16 nonzero
//  irq_valid_o     out  1                   interrupt offer valid
//  irq_hart_o      out  HART_CNT_WIDTH      hart being offered
//  irq_cause_o     out  XPR_LEN             mcause value, {1'b1, code}
//  in_trap_o       out  NUM_HARTS           hart is inside a handler
// BEHAVIOUR
//  Reset:
//  - All MIP bits, in_trap_o, irq_valid_o, irq_hart_o, irq_cause_o and rr_ptr are 0. FSM state is IDLE.
//  MIP register (registered, 1-cycle latency from input to mip_o):
//  - MEIP = ext_irq_i and MTIP = timer_irq_i, sampled every cycle.
//  - MSIP and MVIP are sticky. When set and clear arrive in the same cycle, set wins.
//  Enable mask:
//  - en[h] = mip[h] & mie[h] & mstatus_mie_i[h] & ~in_trap[h].
//  - Cause priority within a hart: MEIP(11) > MSIP(3) > MTIP(7) > MVIP(16).
//  - irq_cause_o = 32'h8000_0000 | code; for example MVU gives 32'h8000_0010.
//  FSM IDLE:
//  - Select the first hart h with |en[h], scanning rr_ptr, rr_ptr+1, ... (mod NUM_HARTS).
//  - If one is found, register irq_hart_o = h and irq_cause_o; next cycle is OFFER with irq_valid_o = 1.
//  FSM OFFER:
//  - irq_hart_o and irq_cause_o are held stable, but are recomputed for the same hart if a higher-priority cause arrives.
//  - irq_ack_i = 1: set in_trap[h], rr_ptr = h+1 (wraps), go to IDLE; irq_valid_o = 0 next cycle.
//  - Otherwise, if en[h] == 0 (masked or cleared): withdraw, go to IDLE, irq_valid_o = 0 next cycle.
//  - Ack in the same cycle as the enable dropping: the ack wins and the trap is taken.
//  - irq_ack_i while irq_valid_o = 0 is ignored.
//  mret_i[h]:
//  - Clears in_trap[h] next cycle.
//  - mret_i[h] and ack for the same h in the same cycle: in_trap[h] stays 1.
//  Level sources:
//  - Level sources are not cleared by ack. The handler clears the source, otherwise the hart is re-offered after MRET.
//  Latency:
//  - mvu_irq_i pulse at cycle N: MVIP visible on mip_o at N+1.
//  - irq_valid_o at N+2 if enabled and FSM IDLE.
//  - At most one trap is offered at a time; back-to-back offers have 1 IDLE cycle between them.
//  Reset mid-offer:
//  - Drops irq_valid_o next cycle and loses all pending MSIP/MVIP state.
// TESTING
//  1 MVU pulse: mvu_irq_i[2] @N, mie[2][16] = 1, mstatus_mie[2] = 1
//    -> mip_o[2] = 32'h0001_0000 @N+1; valid @N+2, hart = 2, cause = 32'h8000_0010.
//    -> ack -> in_trap_o = 8'h04.
//  2 Priority: harts 0 and 5 pending, rr_ptr = 0, hart 0 has MEIP and MTIP
//    -> hart 0 offered with cause 32'h8000_000B.
//    -> after ack, hart 5 offered next; rr_ptr wraps 7 -> 0.
//  3 Withdraw: offering hart 3 MTIP, drop mstatus_mie[3] with no ack
//    -> valid = 0 next cycle, in_trap unchanged.
//    -> same drop plus ack in the same cycle -> trap taken.
//  4 Sticky set/clr: sw_irq_set_i[1] and sw_irq_clr_i[1] in the same cycle -> MSIP[1] = 1.
//    -> clear alone -> 0.
//    -> mret_i[1] and ack for hart 1 in the same cycle -> in_trap[1] = 1.
//  5 Masking: all 8 harts pending with mie = 0 -> valid never asserts.
//    -> enable all -> 8 offers in order 0..7, each acked, none repeated before MRET.
//  6 Reset mid-OFFER -> valid = 0, mip_o = 0, in_trap_o = 0 on the next cycle.

Source files
------------

// File: rtl/pito_irq_ctrl.sv
// rtl/pito_irq_ctrl.sv - per-hart machine interrupt controller and round-robin trap scheduler
module pito_irq_ctrl #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
  parameter int XPR_LEN        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_HARTS-1:0]         ext_irq_i,
  input  logic [NUM_HARTS-1:0]         timer_irq_i,
  input  logic [NUM_HARTS-1:0]         sw_irq_set_i,
  input  logic [NUM_HARTS-1:0]         sw_irq_clr_i,
  input  logic [NUM_HARTS-1:0]         mvu_irq_i,
  input  logic [NUM_HARTS-1:0]         mvu_irq_clr_i,
  input  logic [NUM_HARTS*XPR_LEN-1:0] mie_i,
  input  logic [NUM_HARTS-1:0]         mstatus_mie_i,
  input  logic [NUM_HARTS-1:0]         mret_i,
  input  logic                         irq_ack_i,
  output logic [NUM_HARTS*XPR_LEN-1:0] mip_o,
  output logic                         irq_valid_o,
  output logic [HART_CNT_WIDTH-1:0]    irq_hart_o,
  output logic [XPR_LEN-1:0]           irq_cause_o,
  output logic [NUM_HARTS-1:0]         in_trap_o
);

  localparam int MSIP_BIT = 3;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;
  localparam int MVIP_BIT = 16;

  typedef enum logic {IDLE, OFFER} state_e;

  state_e                    state_q, state_d;
  logic [NUM_HARTS-1:0]      msip_q, msip_d;
  logic [NUM_HARTS-1:0]      mtip_q, mtip_d;
  logic [NUM_HARTS-1:0]      meip_q, meip_d;
  logic [NUM_HARTS-1:0]      mvip_q, mvip_d;
  logic [NUM_HARTS-1:0]      in_trap_q, in_trap_d;
  logic [HART_CNT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [HART_CNT_WIDTH-1:0] hart_q, hart_d;
  logic [XPR_LEN-1:0]        cause_q, cause_d;

  logic [NUM_HARTS-1:0]      en_msip, en_mtip, en_meip, en_mvip, any_en;
  logic                      found;
  logic [HART_CNT_WIDTH-1:0] sel;

  // Only the four implemented MIE bits are consumed; the rest are intentionally ignored.
  logic unused_mie;
  assign unused_mie = ^mie_i;

  // mcause for the highest-priority enabled source: MEIP > MSIP > MTIP > MVIP.
  function automatic logic [XPR_LEN-1:0] cause_code(input logic e, input logic s,
                                                    input logic t, input logic v);
    logic [XPR_LEN-1:0] c;
    c = '0;
    c[XPR_LEN-1] = 1'b1;
    if (e)      c[4:0] = 5'd11;
    else if (s) c[4:0] = 5'd3;
    else if (t) c[4:0] = 5'd7;
    else if (v) c[4:0] = 5'd16;
    return c;
  endfunction

  // Pending-bit next state: levels follow their sources, sticky bits favour set over clear.
  always_comb begin
    meip_d = ext_irq_i;
    mtip_d = timer_irq_i;
    msip_d = sw_irq_set_i | (msip_q & ~sw_irq_clr_i);
    mvip_d = mvu_irq_i | (mvip_q & ~mvu_irq_clr_i);
  end

  // Per-hart enable mask; a hart already inside a handler is never re-offered.
  always_comb begin
    en_msip = '0;
    en_mtip = '0;
    en_meip = '0;
    en_mvip = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      en_msip[h] = msip_q[h] & mie_i[h*XPR_LEN + MSIP_BIT] & mstatus_mie_i[h] & ~in_trap_q[h];
      en_mtip[h] = mtip_q[h] & mie_i[h*XPR_LEN + MTIP_BIT] & mstatus_mie_i[h] & ~in_trap_q[h];
      en_meip[h] = meip_q[h] & mie_i[h*XPR_LEN + MEIP_BIT] & mstatus_mie_i[h] & ~in_trap_q[h];
      en_mvip[h] = mvip_q[h] & mie_i[h*XPR_LEN + MVIP_BIT] & mstatus_mie_i[h] & ~in_trap_q[h];
    end
    any_en = en_msip | en_mtip | en_meip | en_mvip;
  end

  // Round-robin search for the first enabled hart starting at rr_ptr.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_HARTS;
      if (!found && any_en[idx]) begin
        found = 1'b1;
        sel   = HART_CNT_WIDTH'(idx);
      end
    end
  end

  // Offer FSM: pick a hart in IDLE, hold the offer until ack or until its enable drops.
  always_comb begin
    state_d   = state_q;
    hart_d    = hart_q;
    cause_d   = cause_q;
    rr_ptr_d  = rr_ptr_q;
    in_trap_d = in_trap_q & ~mret_i;
    case (state_q)
      IDLE: begin
        if (found) begin
          hart_d  = sel;
          cause_d = cause_code(en_meip[sel], en_msip[sel], en_mtip[sel], en_mvip[sel]);
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (irq_ack_i) begin
          // Setting after the MRET clear lets a same-cycle ack keep the hart in trap.
          in_trap_d[hart_q] = 1'b1;
          rr_ptr_d = (hart_q == HART_CNT_WIDTH'(NUM_HARTS-1)) ? '0 : hart_q + 1'b1;
          state_d  = IDLE;
        end else if (!any_en[hart_q]) begin
          state_d = IDLE;
        end else begin
          cause_d = cause_code(en_meip[hart_q], en_msip[hart_q], en_mtip[hart_q], en_mvip[hart_q]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      msip_q    <= '0;
      mtip_q    <= '0;
      meip_q    <= '0;
      mvip_q    <= '0;
      in_trap_q <= '0;
      rr_ptr_q  <= '0;
      hart_q    <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      msip_q    <= msip_d;
      mtip_q    <= mtip_d;
      meip_q    <= meip_d;
      mvip_q    <= mvip_d;
      in_trap_q <= in_trap_d;
      rr_ptr_q  <= rr_ptr_d;
      hart_q    <= hart_d;
      cause_q   <= cause_d;
    end
  end

  // Pack the pending bits into each hart's MIP image.
  always_comb begin
    mip_o = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mip_o[h*XPR_LEN + MSIP_BIT] = msip_q[h];
      mip_o[h*XPR_LEN + MTIP_BIT] = mtip_q[h];
      mip_o[h*XPR_LEN + MEIP_BIT] = meip_q[h];
      mip_o[h*XPR_LEN + MVIP_BIT] = mvip_q[h];
    end
  end

  assign irq_valid_o = (state_q == OFFER);
  assign irq_hart_o  = hart_q;
  assign irq_cause_o = cause_q;
  assign in_trap_o   = in_trap_q;

endmodule
